// File: rtl/quiz_pkg.sv
// Shared types for the quiz-buzzer arbiter.
// Holds the arbiter state encoding and the default channel count.
package quiz_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } arb_state_t;

   localparam int CH_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// One contestant button: 2-flop synchronizer plus stable-level debouncer.
// rise pulses for one cycle when the debounced level goes 0->1.
module btn_debounce #(
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W      = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam logic [DB_W-1:0] LIMIT = DB_W'(DB_CYCLES);

   logic            s1;
   logic            s2;
   logic [DB_W-1:0] cnt;
   logic [DB_W-1:0] cnt_inc;

   assign cnt_inc = cnt + DB_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         // any sample matching the accepted level restarts the count
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt_inc == LIMIT) begin
            cnt   <= '0;
            level <= s2;
            rise  <= s2;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end

endmodule

// File: rtl/press_arbiter.sv
// First-press quiz arbiter: debounced buttons, IDLE/ARMED/LOCKED FSM.
// Define FOUL_DETECT_EN to flag and exclude false starts made in IDLE.
module press_arbiter
   import quiz_pkg::*;
#(
   parameter int CH        = CH_DEFAULT,
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W      = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] btn_raw,
   input  logic          arm,
   input  logic          clear,
   output logic [CH-1:0] press,
   output logic          press_valid,
   output logic          locked,
   output logic [CH-1:0] foul,
   output logic          buzz_req
);

   arb_state_t state;
   arb_state_t state_nxt;

   logic [CH-1:0] lvl;
   logic [CH-1:0] rise;
   logic [CH-1:0] ev;
   logic [CH-1:0] elig;
   logic [CH-1:0] winner;
   logic [CH-1:0] press_q;
   logic [CH-1:0] press_nxt;
   logic [CH-1:0] foul_q;
   logic          pv_q;
   logic          pv_nxt;

   for (genvar g = 0; g < CH; g++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .DB_W      (DB_W)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[g]),
         .level (lvl[g]),
         .rise  (rise[g])
      );
   end

   assign ev     = rise & lvl;
   assign elig   = ev & ~foul_q;
   // isolate lowest set bit: lowest index wins a tie
   assign winner = elig & (~elig + CH'(1));

`ifdef FOUL_DETECT_EN
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         foul_q <= '0;
      end else if (state == IDLE) begin
         foul_q <= foul_q | ev;
      end
   end
`else
   assign foul_q = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         press_q <= '0;
         pv_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         press_q <= press_nxt;
         pv_q    <= pv_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      press_nxt = press_q;
      pv_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm && !clear) begin
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // clear outranks a same-cycle event
            if (!arm) begin
               state_nxt = IDLE;
            end else if (!clear && (|winner)) begin
               state_nxt = LOCKED;
               press_nxt = winner;
               pv_nxt    = 1'b1;
            end
         end
         LOCKED: begin
            if (clear) begin
               state_nxt = IDLE;
               press_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            press_nxt = '0;
         end
      endcase
   end

   assign press       = press_q;
   assign press_valid = pv_q;
   assign buzz_req    = pv_q;
   assign locked      = (state == LOCKED);
   assign foul        = foul_q;

endmodule

// File: doc/press_arbiter.md
PRESS_ARBITER -- requirements
Module: press_arbiter

Interface
REQ-001 SHALL have parameter CH, default 4: number of contestant channels.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000: cycles a raw level must hold stable before it is accepted.
REQ-003 SHALL have parameter DB_W, default 20: debounce counter width, with DB_W >= clog2(DB_CYCLES+1).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, CH: asynchronous contestant buttons, 1 = pressed.
REQ-007 SHALL have port arm, input, 1: level; host answer window open.
REQ-008 SHALL have port clear, input, 1: single-cycle pulse; host releases the lock for the next question.
REQ-009 SHALL have port press, output, CH: one-hot winner, held while locked, 0 otherwise.
REQ-010 SHALL have port press_valid, output, 1: one-cycle pulse on the cycle press first becomes nonzero.
REQ-011 SHALL have port locked, output, 1: high while a winner is held.
REQ-012 SHALL have port foul, output, CH: sticky false-start flags.
REQ-013 SHALL have port buzz_req, output, 1: high for exactly 1 cycle with press_valid, for beeper trigger.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchronizer.
REQ-015 SHALL debounce each channel independently: the counter counts while the synced input differs from the debounced level, resets to 0 on any match, and flips the debounced level when the count reaches DB_CYCLES.
REQ-016 SHALL generate a press event on a debounced 0->1 transition only; a held button SHALL produce no repeat events.
REQ-017 SHALL implement FSM IDLE, ARMED, LOCKED.
REQ-018 SHALL transition IDLE->ARMED when arm=1 and clear=0.
REQ-019 SHALL transition ARMED->IDLE when arm=0.
REQ-020 SHALL transition ARMED->LOCKED on any event from a channel whose foul bit is 0.
REQ-021 SHALL transition LOCKED->IDLE on clear, independent of arm.
REQ-022 SHALL, on simultaneous eligible events in one cycle, select the lowest channel index as winner.
REQ-023 SHALL register press and press_valid on the cycle of the ARMED->LOCKED transition, giving 1 cycle from event to outputs.
REQ-024 SHALL give total latency from a stable btn_raw edge to press_valid of 2 + DB_CYCLES + 1 cycles.
REQ-025 SHALL ignore events in LOCKED; press SHALL not change.
REQ-026 SHALL, on clear, zero press and locked and clear all foul bits on the next edge.
REQ-027 SHALL give clear priority over a same-cycle event; that event is discarded.
REQ-028 SHALL continue debounce counting across all states so that a button held through clear produces no new event.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set the FSM to IDLE, all synchronizer flops, debounced levels and counters to 0, and press=0, press_valid=0, locked=0, foul=0, buzz_req=0.
REQ-030 SHALL abandon any lock when rst is asserted mid-operation, with no press_valid emitted that cycle.

Configuration
REQ-031 SHALL, with macro FOUL_DETECT_EN defined, set foul[i] on an event on channel i while in IDLE; the foul bit persists until clear or rst and excludes channel i from arbitration.
REQ-032 SHALL, without FOUL_DETECT_EN, tie foul to 0 and silently ignore IDLE events.

Structure
REQ-033 SHALL place the state enum typedef (IDLE/ARMED/LOCKED) and default CH constant in shared package quiz_pkg.
REQ-034 SHALL implement synchronizer plus debouncer as sub-module btn_debounce, instantiated CH times, with outputs level and rise.

Verification (DB_CYCLES=4)
REQ-035 SHALL verify: arm=1, btn_raw=4'b0100 held 10 cycles -> press=4'b0100, press_valid high for 1 cycle exactly 7 cycles after the edge, locked=1.
REQ-036 SHALL verify: arm=1, btn_raw 0->4'b1010 on the same edge -> press=4'b0010.
REQ-037 SHALL verify: arm=1, btn_raw[0] toggles every 2 cycles for 20 cycles -> no press_valid.
REQ-038 SHALL verify (FOUL_DETECT_EN): arm=0, btn_raw[1] pressed -> foul=4'b0010; then arm=1, btn_raw[1] and btn_raw[3] pressed -> press=4'b1000; then clear -> foul=0, press=0.
REQ-039 SHALL verify: while LOCKED on channel 2, a channel-0 event -> press stays 4'b0100; clear on the same cycle as a new event -> IDLE, press=0.
REQ-040 SHALL verify: rst=1 pulse while LOCKED -> all outputs 0 on the next edge and the FSM returns to IDLE.
